// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//
// Issue/retire controller that sits between the decode stage and a
// multi-cycle M-extension divider. It holds at most one divide in flight.
// The op is accepted in IDLE, start is pulsed once in ISSUE, and WAIT
// watches the divider's stall line until the result is ready. Special
// cases (divide-by-zero, signed overflow) take a one-cycle DRAIN detour
// that writes the architectural fix-up value instead of the divider
// result. RESP then holds a write-back request until it is accepted.
// A WAIT that runs too long completes with an error flag and zero data.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   clear                synchronous flush back to IDLE, discards everything
//   req_valid/req_ready  request handshake from decode (ready only in IDLE)
//   req_op/a/b/rd        divide operation, operands and destination register
//   div_start            one-cycle start pulse to the divider
//   div_op/div_a/div_b   latched op and operands, stable while busy
//   div_stall/dbz/ovf    divider status inputs
//   div_result           divider result
//   busy, busy_rd        in-flight indicator and its destination (hazards)
//   wb_valid/wb_ready    write-back handshake
//   wb_rd/wb_data/wb_err write-back payload; wb_err marks a timeout
// ---------------------------------------------------------------------------

package div_issue_pkg;

    typedef enum logic [1:0] {
        ALU_DIV  = 2'd0,
        ALU_DIVU = 2'd1,
        ALU_REM  = 2'd2,
        ALU_REMU = 2'd3
    } alu_t;

endpackage

module div_issue_ctrl
    import div_issue_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,

    input  logic             req_valid,
    output logic             req_ready,
    input  alu_t             req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [4:0]       req_rd,

    output logic             div_start,
    output alu_t             div_op,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_stall,
    input  logic             div_dbz,
    input  logic             div_ovf,
    input  logic [WIDTH-1:0] div_result,

    output logic             busy,
    output logic [4:0]       busy_rd,

    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // The wait counter holds the number of WAIT cycles already spent, so the
    // TIMEOUT-th WAIT cycle is the one that sees TIMEOUT-1.
    localparam logic [5:0]       TIMEOUT_LAST = 6'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] MOST_NEG     = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    alu_t             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [4:0]       rd_q, rd_d;
    logic [5:0]       wait_cnt_q, wait_cnt_d;
    logic             seen_stall_q, seen_stall_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             wb_err_q, wb_err_d;

    logic             is_quotient;
    logic [WIDTH-1:0] fixup;

    // Architectural special-case results, derived only from the latched
    // operands. A zero divisor decides between the two cases; anything else
    // reaching DRAIN is the signed overflow, whose quotient is the most
    // negative value and whose remainder is zero.
    always_comb begin
        is_quotient = (op_q == ALU_DIV) || (op_q == ALU_DIVU);
        fixup       = '0;
        if (b_q == '0) begin
            fixup = is_quotient ? '1 : a_q;
        end else begin
            fixup = is_quotient ? MOST_NEG : '0;
        end
    end

    // Next-state and datapath-register logic. Divider status is only
    // meaningful in WAIT; special cases beat normal completion, which beats
    // the timeout. A synchronous clear overrides every transition and wipes
    // the in-flight op together with any pending write-back.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rd_d         = rd_q;
        wait_cnt_d   = wait_cnt_q;
        seen_stall_d = seen_stall_q;
        wb_data_d    = wb_data_q;
        wb_err_d     = wb_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d         = req_op;
                    a_d          = req_a;
                    b_d          = req_b;
                    rd_d         = req_rd;
                    wait_cnt_d   = '0;
                    seen_stall_d = 1'b0;
                    wb_err_d     = 1'b0;
                    state_d      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 6'd1;
                if (div_stall) begin
                    seen_stall_d = 1'b1;
                end
                if (div_dbz || div_ovf) begin
                    state_d = S_DRAIN;
                end else if (seen_stall_q && !div_stall) begin
                    wb_data_d = div_result;
                    wb_err_d  = 1'b0;
                    state_d   = S_RESP;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    wb_data_d = '0;
                    wb_err_d  = 1'b1;
                    state_d   = S_RESP;
                end
            end

            // One cycle here lets the divider finish its special-case
            // finalize before a new op can be started.
            S_DRAIN: begin
                wb_data_d = fixup;
                wb_err_d  = 1'b0;
                state_d   = S_RESP;
            end

            S_RESP: begin
                if (wb_ready) begin
                    wb_err_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clear) begin
            state_d      = S_IDLE;
            op_d         = ALU_DIV;
            a_d          = '0;
            b_d          = '0;
            rd_d         = '0;
            wait_cnt_d   = '0;
            seen_stall_d = 1'b0;
            wb_data_d    = '0;
            wb_err_d     = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= ALU_DIV;
            a_q          <= '0;
            b_q          <= '0;
            rd_q         <= '0;
            wait_cnt_q   <= '0;
            seen_stall_q <= 1'b0;
            wb_data_q    <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rd_q         <= rd_d;
            wait_cnt_q   <= wait_cnt_d;
            seen_stall_q <= seen_stall_d;
            wb_data_q    <= wb_data_d;
            wb_err_q     <= wb_err_d;
        end
    end

    // Outputs are decoded from the state register so nothing glitches on
    // inputs. rd and err are gated so they read zero outside their window.
    assign req_ready = (state_q == S_IDLE);
    assign div_start = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE);
    assign busy_rd   = busy ? rd_q : 5'd0;
    assign div_op    = op_q;
    assign div_a     = a_q;
    assign div_b     = b_q;
    assign wb_valid  = (state_q == S_RESP);
    assign wb_rd     = wb_valid ? rd_q : 5'd0;
    assign wb_data   = wb_data_q;
    assign wb_err    = wb_valid && wb_err_q;

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 48, giving the maximum number of WAIT cycles before an error completion.
REQ-003 Port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1, reset; reset SHALL be asynchronous and active-high.
REQ-005 Port clear, input, 1, synchronous flush; when high it SHALL return the block to IDLE.
REQ-006 Port req_valid, input, 1, the decode stage presents an M-extension divide op.
REQ-007 Port req_ready, output, 1, high only in IDLE.
REQ-008 Port req_op, input, alu_t, one of DIV, DIVU, REM or REMU.
REQ-009 Port req_a / req_b, input, WIDTH each, dividend and divisor.
REQ-010 Port req_rd, input, 5, destination register.
REQ-011 Port div_start, output, 1, drives the divider's i_p_signal.
REQ-012 Port div_op, output, alu_t, latched op.
REQ-013 Port div_a / div_b, output, WIDTH each, latched operands.
REQ-014 Ports div_stall, div_dbz and div_ovf, input, 1 each, divider status.
REQ-015 Port div_result, input, WIDTH, divider result.
REQ-016 Port busy, output, 1, high whenever state is not IDLE.
REQ-017 Port busy_rd, output, 5, latched rd while busy, otherwise 0; used for hazard detection.
REQ-018 Port wb_valid, output, 1, write-back request.
REQ-019 Port wb_ready, input, 1, write-back accept.
REQ-020 Port wb_rd, output, 5, write-back destination register.
REQ-021 Port wb_data, output, WIDTH, write-back data.
REQ-022 Port wb_err, output, 1, high when the completion was caused by a timeout.

Function
REQ-023 States SHALL be IDLE, ISSUE, WAIT, DRAIN and RESP.
REQ-024 On req_valid & req_ready the block SHALL latch op, a, b and rd, then go to ISSUE.
REQ-025 In ISSUE the block SHALL drive div_start=1 for exactly one cycle, then go to WAIT; div_start SHALL be 0 in every other state.
REQ-026 The op, a and b outputs to the divider SHALL be stable from ISSUE until the block returns to IDLE.
REQ-027 In WAIT, the block SHALL set an internal seen_stall flag when div_stall=1.
REQ-028 In WAIT, div_dbz=1 or div_ovf=1 SHALL take priority over all other WAIT conditions and go to DRAIN.
REQ-029 In WAIT, seen_stall=1 with div_stall=0 SHALL capture div_result into wb_data and go to RESP.
REQ-030 In WAIT, a 6-bit wait counter SHALL increment each cycle.
REQ-031 If the wait counter reaches TIMEOUT with no completion, the block SHALL go to RESP with wb_err=1 and wb_data=0.
REQ-032 DRAIN SHALL last exactly one cycle so the divider's special-case FINALIZE completes before any new issue.
REQ-033 DRAIN SHALL load wb_data with the architectural fix-up value computed from the latched operands; div_result SHALL be ignored in this path.
REQ-034 Divide-by-zero fix-up: DIV and DIVU SHALL return all ones; REM and REMU SHALL return the dividend.
REQ-035 Overflow fix-up (DIV or REM with a = 0x80000000 and b = -1): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-036 In RESP, wb_valid SHALL be 1 with wb_rd equal to the latched rd.
REQ-037 wb_valid, wb_rd, wb_data and wb_err SHALL hold stable until wb_ready=1.
REQ-038 On wb_valid & wb_ready the block SHALL go to IDLE, and req_ready SHALL be 1 on the following cycle.
REQ-039 The block SHALL accept no new request while not in IDLE; there is no pipelining and at most one op is in flight.
REQ-040 Normal-path latency SHALL be wb_valid exactly 1 cycle after the first cycle in which div_stall is observed falling in WAIT.
REQ-041 Special-case latency SHALL be wb_valid 3 cycles after request acceptance.
REQ-042 clear SHALL have priority over every transition; the in-flight op and any pending write-back are discarded with no wb_valid.

Reset
REQ-043 While rst is high, and asynchronously on its assertion, the block SHALL force state to IDLE.
REQ-044 Under reset, req_ready SHALL be 1.
REQ-045 Under reset, div_start, busy, wb_valid and wb_err SHALL be 0.
REQ-046 Under reset, busy_rd, wb_rd and wb_data SHALL be 0, and div_op, div_a, div_b, the wait counter and seen_stall SHALL be cleared.
REQ-047 Reset asserted mid-operation SHALL abandon the op without producing a write-back.

Verification
REQ-048 DIV a=20, b=-3 (0xFFFFFFFD), rd=5, with the real divider attached -> one div_start pulse, then wb_valid with wb_rd=5 and wb_data=0xFFFFFFFA.
REQ-049 REMU a=7, b=0 -> DRAIN path, wb_valid 3 cycles after acceptance with wb_data=7. Repeat with DIVU -> wb_data=0xFFFFFFFF.
REQ-050 DIV a=0x80000000, b=0xFFFFFFFF -> wb_data=0x80000000. Repeat with REM -> wb_data=0.
REQ-051 Hold wb_ready=0 for 5 cycles in RESP -> wb outputs unchanged, req_ready=0 throughout, and IDLE on the cycle after wb_ready=1.
REQ-052 Assert rst mid-WAIT, then clear mid-WAIT in a separate run -> all outputs return to reset values, no wb_valid, and the next request completes correctly.
REQ-053 Stub divider holding div_stall=1 permanently -> wb_valid with wb_err=1 and wb_data=0 after TIMEOUT WAIT cycles.
